// File: rtl/fifo_pop_serializer_pkg.sv
// Shared types and helpers for the FIFO pop-side serializer.
package fifo_pop_serializer_pkg;

  typedef enum logic [0:0] {IDLE, SEND} ser_state_t;

  // Beat-counter width; never below one bit so the counter always exists.
  function automatic int beat_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_pop_serializer.sv
// Pops wide words from a FIFO and emits them as narrow valid/ready beats.
// Define FIFO_POP_SERIALIZER_MSB_FIRST_EN for MSB-first beat order (default LSB-first).
module fifo_pop_serializer
  import fifo_pop_serializer_pkg::*;
#(
  parameter int in_width  = 32,
  parameter int out_width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [in_width-1:0]  fifo_read_data,
  output logic                 fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [out_width-1:0] out_data,
  output logic                 out_last
);

  localparam int ratio = in_width / out_width;
  localparam int BW    = beat_width(ratio);
  localparam logic [BW-1:0] LAST_BEAT = BW'(ratio - 1);

  if ((in_width % out_width) != 0 || ratio < 2) begin : g_bad_ratio
    $error("fifo_pop_serializer: in_width must be a multiple of out_width with ratio >= 2");
  end

  ser_state_t          r_state;
  logic [BW-1:0]       r_beat;
  logic [in_width-1:0] r_shift;
  logic [in_width-1:0] w_shifted;
  logic                w_at_last;
  logic                w_load;

  assign w_at_last = (r_state == SEND) && (r_beat == LAST_BEAT);

  // A new word is taken either from idle or on the final-beat handshake, so
  // back-to-back words stream without a bubble.
  assign w_load = !rst && !fifo_empty &&
                  ((r_state == IDLE) || (w_at_last && out_ready));

  assign fifo_pop  = w_load;
  assign out_valid = (r_state == SEND);
  assign out_last  = w_at_last;

`ifdef FIFO_POP_SERIALIZER_MSB_FIRST_EN
  assign out_data  = r_shift[in_width-1 -: out_width];
  assign w_shifted = {r_shift[in_width-out_width-1:0], {out_width{1'b0}}};
`else
  assign out_data  = r_shift[out_width-1:0];
  assign w_shifted = {{out_width{1'b0}}, r_shift[in_width-1:out_width]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_shift <= '0;
    end else if (w_load) begin
      r_state <= SEND;
      r_beat  <= '0;
      r_shift <= fifo_read_data;
    end else if (r_state == SEND && out_ready) begin
      r_shift <= w_shifted;
      if (r_beat == LAST_BEAT) begin
        r_state <= IDLE;
        r_beat  <= '0;
      end else begin
        r_beat  <= r_beat + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// Directed bench for fifo_pop_serializer (32-bit words, 8-bit beats) with a queue-backed FIFO.
module tb_fifo_pop_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_empty;
  logic [31:0] fifo_read_data;
  logic        fifo_pop;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  fifo_pop_serializer #(.in_width(32), .out_width(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
    .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected beat k of a word, hand-ordered for the selected build.
  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int k);
    logic [31:0] t;
`ifdef FIFO_POP_SERIALIZER_MSB_FIRST_EN
    t = w >> (8 * (3 - k));
`else
    t = w >> (8 * k);
`endif
    return t[7:0];
  endfunction

  function automatic void sync_fifo();
    fifo_empty     = (q.size() == 0);
    fifo_read_data = (q.size() == 0) ? 32'h0 : q[0];
  endfunction

  // Advance one clock; the FIFO head moves if a pop was seen before the edge.
  task automatic tick();
    logic p;
    p = fifo_pop;
    chk("pop_while_empty", 32'(p & fifo_empty), 32'h0);
    if (p) pops++;
    @(posedge clk);
    @(negedge clk);
    if (p) void'(q.pop_front());
    sync_fifo();
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] w, input int k, input logic exp_pop);
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_data"},  32'(out_data), 32'(exp_beat(w, k)));
    chk({tag, "_last"},  32'(out_last), 32'(k == 3));
    chk({tag, "_pop"},   32'(fifo_pop), 32'(exp_pop));
    $display("beat %s k=%0d data=%h last=%0d pop=%0d", tag, k, out_data, out_last, fifo_pop);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    q.push_back(32'hAABBCCDD);
    sync_fifo();
    @(negedge clk); #1;

    // Reset held with a non-empty FIFO: nothing may be popped.
    chk("rst_pop0", 32'(fifo_pop), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pop", 32'(fifo_pop), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_last", 32'(out_last), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
    end
    rst = 1'b0; #1;
    chk("rel_pop", 32'(fifo_pop), 32'h1);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk_beat("rel", 32'hAABBCCDD, k, 1'b0);
      tick();
    end
    chk("rel_idle_valid", 32'(out_valid), 32'h0);

    // Back-to-back words with a ready sink.
    q.push_back(32'h04030201);
    q.push_back(32'h08070605);
    sync_fifo(); #1;
    pops = 0;
    chk("b2b_pop_first", 32'(fifo_pop), 32'h1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk_beat("b2b", (i < 4) ? 32'h04030201 : 32'h08070605, i % 4, i == 3);
      tick();
    end
    chk("b2b_idle_valid", 32'(out_valid), 32'h0);
    chk("b2b_pop_count", 32'(pops), 32'd2);

    // Backpressure on beat 1 while another word waits in the FIFO.
    q.push_back(32'h11223344);
    q.push_back(32'h55667788);
    sync_fifo(); #1;
    tick();
    chk_beat("bp", 32'h11223344, 0, 1'b0);
    tick();
    out_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk_beat("bp_hold", 32'h11223344, 1, 1'b0);
      tick();
    end
    out_ready = 1'b1; #1;
    for (int k = 1; k < 4; k++) begin
      chk_beat("bp", 32'h11223344, k, k == 3);
      tick();
    end

    // Drain the final word and stay empty.
    pops = 0;
    for (int k = 0; k < 4; k++) begin
      chk_beat("drain", 32'h55667788, k, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      chk("drain_valid", 32'(out_valid), 32'h0);
      chk("drain_pop", 32'(fifo_pop), 32'h0);
      tick();
    end
    chk("drain_pop_count", 32'(pops), 32'd0);

    // Reset mid-word with the last beat on offer and another word queued.
    q.push_back(32'hCAFEF00D);
    q.push_back(32'hDEADBEEF);
    sync_fifo(); #1;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk_beat("mid", 32'hCAFEF00D, k, 1'b0);
      tick();
    end
    rst = 1'b1; #1;
    chk("mid_rst_pop", 32'(fifo_pop), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_last", 32'(out_last), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_pop2", 32'(fifo_pop), 32'h0);
    rst = 1'b0; #1;
    chk("mid_rel_pop", 32'(fifo_pop), 32'h1);
    tick();
    chk_beat("mid_next", 32'hDEADBEEF, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
